sseg_mux_capture: RTL and testbench

- Receive-side monitor for the 4-digit multiplexed seven-segment interface: samples the time-multiplexed, active-low digit-enable strobes and segment bus, reconstructs the four per-digit segment patterns and decodes them to hex nibbles.
- Sits beside the display driver on the board, or in a bench, as a self-check and readback path: a frame-complete pulse after all four digits are captured, plus error and stale status.

---
 rtl/sseg_pkg.sv | 35 +++
 rtl/sseg_mux_capture_if.sv | 9 +
 rtl/sseg_to_hex.sv | 35 +++
 rtl/sseg_mux_capture.sv | 162 ++++++++++++++++
 tb/tb_sseg_mux_capture.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sseg_pkg.sv
// Shared segment codes, capture FSM states and the one-hot-low slot check
// for the seven-segment mux capture block.
package sseg_pkg;

   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_A     = 8'h88;
   localparam logic [7:0] SEG_B     = 8'h83;
   localparam logic [7:0] SEG_C     = 8'hC6;
   localparam logic [7:0] SEG_D     = 8'hA1;
   localparam logic [7:0] SEG_E     = 8'h86;
   localparam logic [7:0] SEG_F     = 8'h8E;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   typedef enum logic [1:0] {
      ST_WAIT,
      ST_SETTLE,
      ST_HELD
   } cap_state_e;

   function automatic logic one_low(input logic [3:0] en);
      logic [3:0] l;
      l = ~en;
      return (l != 4'h0) && ((l & (l - 4'h1)) == 4'h0);
   endfunction

endpackage

// File: rtl/sseg_mux_capture_if.sv
// Multiplexed seven-segment bus as seen by the display driver (master)
// and by the capture monitor (slave).
interface sseg_mux_capture_if;
   logic [3:0] en_dig;
   logic [7:0] sseg;

   modport master (output en_dig, output sseg);
   modport slave  (input  en_dig, input  sseg);
endinterface

// File: rtl/sseg_to_hex.sv
// Combinational active-low gfedcba pattern to hex nibble decoder;
// valid drops for any pattern outside 0-F.
module sseg_to_hex
   import sseg_pkg::*;
(
   input  logic [6:0] seg,
   output logic       valid,
   output logic [3:0] nib
);

   always_comb begin
      valid = 1'b1;
      nib   = 4'h0;
      unique case (seg)
         SEG_0[6:0]: nib = 4'h0;
         SEG_1[6:0]: nib = 4'h1;
         SEG_2[6:0]: nib = 4'h2;
         SEG_3[6:0]: nib = 4'h3;
         SEG_4[6:0]: nib = 4'h4;
         SEG_5[6:0]: nib = 4'h5;
         SEG_6[6:0]: nib = 4'h6;
         SEG_7[6:0]: nib = 4'h7;
         SEG_8[6:0]: nib = 4'h8;
         SEG_9[6:0]: nib = 4'h9;
         SEG_A[6:0]: nib = 4'hA;
         SEG_B[6:0]: nib = 4'hB;
         SEG_C[6:0]: nib = 4'hC;
         SEG_D[6:0]: nib = 4'hD;
         SEG_E[6:0]: nib = 4'hE;
         SEG_F[6:0]: nib = 4'hF;
         default:    valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/sseg_mux_capture.sv
// Seven-segment mux capture monitor: rebuilds the four digit patterns.
// Define SSEG_CAP_HEXDEC_EN to enable hex decoding and code_err.
module sseg_mux_capture
   import sseg_pkg::*;
#(
   parameter int STABLE_CYC = 4,
   parameter int TMO_W      = 20
) (
   input  logic               clk,
   input  logic               reset_n,
   sseg_mux_capture_if.slave  bus,
   output logic [7:0]         dig3,
   output logic [7:0]         dig2,
   output logic [7:0]         dig1,
   output logic [7:0]         dig0,
   output logic [15:0]        hex,
   output logic [3:0]         dp,
   output logic [3:0]         seen,
   output logic               frame_valid,
   output logic               code_err,
   output logic               enable_err,
   output logic               stale
);

   localparam logic [TMO_W-1:0] TMO_MAX = '1;
   localparam logic [7:0]       STABLE  = 8'(STABLE_CYC);

   logic [3:0]       en_s1_q, en_s2_q;
   logic [7:0]       sg_s1_q, sg_s2_q;
   logic [11:0]      prev_q;
   cap_state_e       state_q, state_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [7:0]       dig_q [4];
   logic [7:0]       dig_d [4];
   logic [15:0]      hex_q, hex_d;
   logic [3:0]       dp_q, dp_d;
   logic [3:0]       seen_q, seen_d;
   logic             fv_q, fv_d;
   logic             cerr_q, cerr_d;
   logic             eerr_q, eerr_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             stale_q, stale_d;

   logic [11:0] cur;
   logic        slot_ok, slot_bad, restart, latch;
   logic        nib_ok;
   logic [3:0]  nib;

   assign cur      = {en_s2_q, sg_s2_q};
   assign slot_ok  = one_low(en_s2_q);
   assign slot_bad = !slot_ok && (en_s2_q != 4'hF);

`ifdef SSEG_CAP_HEXDEC_EN
   sseg_to_hex u_dec (
      .seg   (sg_s2_q[6:0]),
      .valid (nib_ok),
      .nib   (nib)
   );
`else
   assign nib_ok = 1'b1;
   assign nib    = 4'h0;
`endif

   // A run of identical valid samples latches exactly once, at STABLE_CYC.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      restart = 1'b0;
      latch   = 1'b0;
      if (!slot_ok) begin
         state_d = ST_WAIT;
         cnt_d   = '0;
      end else begin
         restart = (state_q == ST_WAIT) || (cur != prev_q);
         if (restart)
            cnt_d = 8'd1;
         else if (state_q == ST_SETTLE)
            cnt_d = cnt_q + 8'd1;
         latch = (restart || state_q == ST_SETTLE) && (cnt_d == STABLE);
         if (latch)
            state_d = ST_HELD;
         else if (restart)
            state_d = ST_SETTLE;
      end
   end

   always_comb begin
      dig_d   = dig_q;
      hex_d   = hex_q;
      dp_d    = dp_q;
      cerr_d  = cerr_q;
      fv_d    = (seen_q == 4'hF);
      seen_d  = fv_d ? 4'h0 : seen_q;
      eerr_d  = eerr_q | slot_bad;
      tmo_d   = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TMO_W'(1);
      stale_d = stale_q | (tmo_d == TMO_MAX);
      if (latch) begin
         tmo_d   = '0;
         stale_d = 1'b0;
         seen_d  = seen_d | ~en_s2_q;
         cerr_d  = cerr_q | !nib_ok;
         for (int i = 0; i < 4; i++) begin
            if (!en_s2_q[i]) begin
               dig_d[i]         = sg_s2_q;
               dp_d[i]          = ~sg_s2_q[7];
               hex_d[4*i +: 4]  = nib;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         en_s1_q <= 4'hF;
         en_s2_q <= 4'hF;
         sg_s1_q <= SEG_BLANK;
         sg_s2_q <= SEG_BLANK;
         prev_q  <= {4'hF, SEG_BLANK};
         state_q <= ST_WAIT;
         cnt_q   <= '0;
         dig_q   <= '{default: SEG_BLANK};
         hex_q   <= '0;
         dp_q    <= '0;
         seen_q  <= '0;
         fv_q    <= 1'b0;
         cerr_q  <= 1'b0;
         eerr_q  <= 1'b0;
         tmo_q   <= '0;
         stale_q <= 1'b1;
      end else begin
         en_s1_q <= bus.en_dig;
         en_s2_q <= en_s1_q;
         sg_s1_q <= bus.sseg;
         sg_s2_q <= sg_s1_q;
         prev_q  <= cur;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dig_q   <= dig_d;
         hex_q   <= hex_d;
         dp_q    <= dp_d;
         seen_q  <= seen_d;
         fv_q    <= fv_d;
         cerr_q  <= cerr_d;
         eerr_q  <= eerr_d;
         tmo_q   <= tmo_d;
         stale_q <= stale_d;
      end
   end

   assign dig3        = dig_q[3];
   assign dig2        = dig_q[2];
   assign dig1        = dig_q[1];
   assign dig0        = dig_q[0];
   assign hex         = hex_q;
   assign dp          = dp_q;
   assign seen        = seen_q;
   assign frame_valid = fv_q;
   assign code_err    = cerr_q;
   assign enable_err  = eerr_q;
   assign stale       = stale_q;

endmodule

// File: tb/tb_sseg_mux_capture.sv
// Bench for sseg_mux_capture: sample-stream model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_sseg_mux_capture;

   localparam int STABLE  = 4;
   localparam int TMO_MAX = 15;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [7:0]  dig3, dig2, dig1, dig0;
   logic [15:0] hex;
   logic [3:0]  dp, seen;
   logic        frame_valid, code_err, enable_err, stale;

   sseg_mux_capture_if bus ();

   sseg_mux_capture #(.STABLE_CYC(STABLE), .TMO_W(4)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .bus         (bus.slave),
      .dig3        (dig3),
      .dig2        (dig2),
      .dig1        (dig1),
      .dig0        (dig0),
      .hex         (hex),
      .dp          (dp),
      .seen        (seen),
      .frame_valid (frame_valid),
      .code_err    (code_err),
      .enable_err  (enable_err),
      .stale       (stale)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int fv_cnt = 0;

   logic [7:0]  codes [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92,
                              8'h82, 8'hF8, 8'h80, 8'h90, 8'h88, 8'h83,
                              8'hC6, 8'hA1, 8'h86, 8'h8E};

   // Model: input stream seen two edges late, run length of equal samples.
   logic [11:0] h0, h1, runval;
   int          run, m_tmo;
   logic [7:0]  m_dig [4];
   logic [15:0] m_hex;
   logic [3:0]  m_dp, m_seen;
   logic        m_fv, m_cerr, m_eerr, m_stale;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      h0 = 12'hFFF; h1 = 12'hFFF; runval = 12'hFFF;
      run = 0; m_tmo = 0;
      for (int i = 0; i < 4; i++) m_dig[i] = 8'hFF;
      m_hex = 0; m_dp = 0; m_seen = 0;
      m_fv = 0; m_cerr = 0; m_eerr = 0; m_stale = 1;
   endtask

   task automatic model_edge(input logic [3:0] e, input logic [7:0] s);
      logic [11:0] smp;
      logic [3:0]  low;
      bit          lt, ok;
      int          di, nb;
      smp = h1; h1 = h0; h0 = {e, s};
      low = ~smp[11:8];
      lt = 0; di = 0;
      if ($countones(low) == 1) begin
         if (run > 0 && smp == runval) run++;
         else begin run = 1; runval = smp; end
         lt = (run == STABLE);
         for (int i = 0; i < 4; i++) if (low[i]) di = i;
      end else begin
         run = 0;
         if ($countones(low) > 1) m_eerr = 1;
      end
      m_fv = (m_seen == 4'hF);
      if (m_fv) begin m_seen = 0; fv_cnt++; end
      if (lt) begin
         m_dig[di] = smp[7:0];
         m_dp[di] = ~smp[7];
         m_seen[di] = 1'b1;
         m_tmo = 0; m_stale = 0;
`ifdef SSEG_CAP_HEXDEC_EN
         ok = 0; nb = 0;
         for (int k = 0; k < 16; k++)
            if (codes[k][6:0] == smp[6:0]) begin ok = 1; nb = k; end
         m_hex[di*4 +: 4] = 4'(nb);
         if (!ok) m_cerr = 1;
`endif
      end else begin
         if (m_tmo < TMO_MAX) m_tmo++;
         if (m_tmo == TMO_MAX) m_stale = 1;
      end
   endtask

   task automatic compare();
      chk("dig3", 32'(dig3), 32'(m_dig[3]));
      chk("dig2", 32'(dig2), 32'(m_dig[2]));
      chk("dig1", 32'(dig1), 32'(m_dig[1]));
      chk("dig0", 32'(dig0), 32'(m_dig[0]));
      chk("hex", 32'(hex), 32'(m_hex));
      chk("dp", 32'(dp), 32'(m_dp));
      chk("seen", 32'(seen), 32'(m_seen));
      chk("frame_valid", 32'(frame_valid), 32'(m_fv));
      chk("code_err", 32'(code_err), 32'(m_cerr));
      chk("enable_err", 32'(enable_err), 32'(m_eerr));
      chk("stale", 32'(stale), 32'(m_stale));
   endtask

   task automatic step(input logic [3:0] e, input logic [7:0] s, input int n);
      for (int k = 0; k < n; k++) begin
         bus.en_dig = e;
         bus.sseg   = s;
         @(posedge clk);
         #1;
         model_edge(e, s);
         compare();
      end
   endtask

   task automatic scan(input logic [7:0] p3, input logic [7:0] p2,
                       input logic [7:0] p1, input logic [7:0] p0,
                       input int n);
      step(4'b0111, p3, n);
      step(4'b1011, p2, n);
      step(4'b1101, p1, n);
      step(4'b1110, p0, n);
   endtask

   task automatic do_reset();
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      compare();
      chk("rst_async_dig2", 32'(dig2), 32'h0000_00FF);
      chk("rst_async_stale", 32'(stale), 32'h1);
      chk("rst_async_seen", 32'(seen), 32'h0);
      @(posedge clk);
      #1;
      compare();
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b1;
      bus.en_dig = 4'hF;
      bus.sseg = 8'hFF;
      model_reset();
      @(posedge clk);
      #1;
      do_reset();
      chk("reset_dig0", 32'(dig0), 32'hFF);
      chk("reset_hex", 32'(hex), 32'h0);

      // Normal scanning, two full frames
      fv_cnt = 0;
      scan(8'hF9, 8'hF8, 8'hC0, 8'h90, 16);
      scan(8'hF9, 8'hF8, 8'hC0, 8'h90, 16);
      step(4'hF, 8'hFF, 4);
      chk("scan_dig3", 32'(dig3), 32'hF9);
      chk("scan_dig2", 32'(dig2), 32'hF8);
      chk("scan_dig1", 32'(dig1), 32'hC0);
      chk("scan_dig0", 32'(dig0), 32'h90);
      chk("scan_dp", 32'(dp), 32'h0);
      chk("scan_frames", 32'(fv_cnt), 32'd2);
      chk("scan_cerr", 32'(code_err), 32'h0);
`ifdef SSEG_CAP_HEXDEC_EN
      chk("scan_hex", 32'(hex), 32'h1709);
`else
      chk("scan_hex", 32'(hex), 32'h0);
`endif

      // Short, glitching slot must not latch
      step(4'b1101, 8'hA4, 2);
      step(4'b1101, 8'hB0, 1);
      step(4'b1101, 8'hA4, 2);
      step(4'hF, 8'hFF, 4);
      chk("glitch_dig1", 32'(dig1), 32'hC0);
      chk("glitch_seen", 32'(seen), 32'h0);
      step(4'b1101, 8'h99, 4);
      step(4'hF, 8'hFF, 3);
      chk("stable_dig1", 32'(dig1), 32'h99);
      chk("stable_seen", 32'(seen), 32'h2);

      // Two enables low
      step(4'b0011, 8'hFF, 10);
      step(4'hF, 8'hFF, 3);
      chk("en_err_set", 32'(enable_err), 32'h1);
      chk("en_err_seen", 32'(seen), 32'h2);
      scan(8'h88, 8'h83, 8'hC6, 8'hA1, 8);
      step(4'hF, 8'hFF, 3);
      chk("en_err_sticky", 32'(enable_err), 32'h1);
`ifdef SSEG_CAP_HEXDEC_EN
      chk("abcd_hex", 32'(hex), 32'hABCD);
`endif

      // Blank code, decimal points
      step(4'b1011, 8'h7F, 8);
      step(4'b1110, 8'h8E, 8);
      step(4'b1101, 8'h06, 8);
      step(4'hF, 8'hFF, 3);
      chk("blank_dig2", 32'(dig2), 32'h7F);
      chk("dp_bits", 32'(dp), 32'h6);
`ifdef SSEG_CAP_HEXDEC_EN
      chk("blank_cerr", 32'(code_err), 32'h1);
      chk("blank_hex", 32'(hex), 32'hA0EF);
`else
      chk("blank_cerr", 32'(code_err), 32'h0);
`endif

      // Inactivity timeout
      step(4'hF, 8'hFF, 20);
      chk("stale_set", 32'(stale), 32'h1);
      step(4'b0111, 8'hC0, 6);
      chk("stale_clr", 32'(stale), 32'h0);
      step(4'hF, 8'hFF, 2);

      // Reset mid-scan, then one clean frame
      step(4'b0111, 8'hF9, 16);
      step(4'b1011, 8'hA4, 16);
      step(4'b1101, 8'hB0, 5);
      do_reset();
      chk("midrst_dig3", 32'(dig3), 32'hFF);
      chk("midrst_eerr", 32'(enable_err), 32'h0);
      fv_cnt = 0;
      scan(8'hF9, 8'hA4, 8'hB0, 8'h99, 16);
      step(4'hF, 8'hFF, 4);
      chk("midrst_frames", 32'(fv_cnt), 32'd1);
`ifdef SSEG_CAP_HEXDEC_EN
      chk("midrst_hex", 32'(hex), 32'h1234);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
